// File: rtl/qr_pkg.sv
// qr_result_streamer shared types and sizes.
// Matrix word geometry and FSM state encoding.
package qr_pkg;
  localparam int WIDTH  = 13;
  localparam int NWORDS = 32;
  localparam int AW     = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } qr_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    addr;
  } qr_word_t;
endpackage

// File: rtl/qr_result_streamer_if.sv
// Result stream bundle: valid/ready word with source address.
// master drives the word, slave returns ready.
interface qr_result_streamer_if;
  import qr_pkg::*;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [AW-1:0]    m_addr;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_addr,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_addr,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/qr_sync_fifo.sv
// Small first-word-fall-through FIFO with occupancy count.
// Push on full is accepted only together with a pop.
module qr_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rptr];

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qr_result_streamer.sv
// Dumps the QR_CORDIC result RAM in address order
// onto a valid/ready stream once the core finishes.
module qr_result_streamer
  import qr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 matr_rd,
  output logic [AW-1:0]        matr_rd_addr,
  input  logic [WIDTH-1:0]     matr_di,
  qr_result_streamer_if.master m,
  output logic                 busy,
  output logic                 dump_done
);
  localparam int CW = $clog2(DEPTH) + 1;

  qr_state_t       state;
  logic            start_q;
  logic            launch;
  logic [AW-1:0]   rd_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            credit_ok;
  logic            fifo_empty;
  logic            pop;
  qr_word_t        push_word;
  qr_word_t        head;

  assign launch    = start & ~start_q & (state == IDLE);
  assign used      = (CW+1)'(fifo_count) + (CW+1)'(matr_rd);
  assign credit_ok = used < (CW+1)'(DEPTH);

  assign push_word.data = matr_di;
  assign push_word.addr = matr_rd_addr;

  assign pop       = m.m_valid & m.m_ready;
  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = m.m_valid ? head.data : '0;
  assign m.m_addr  = m.m_valid ? head.addr : '0;
  assign m.m_last  = m.m_valid & (head.addr == AW'(NWORDS-1));

  // Previous start level; resets high so a level held
  // across reset release needs a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) start_q <= 1'b1;
    else        start_q <= start;
  end

  // Dump sequencer with registered read port and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      matr_rd      <= 1'b0;
      matr_rd_addr <= '0;
      busy         <= 1'b0;
      dump_done    <= 1'b0;
    end else begin
      matr_rd   <= 1'b0;
      dump_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state  <= READ;
            busy   <= 1'b1;
            rd_cnt <= '0;
          end
        end
        READ: begin
          if (credit_ok) begin
            matr_rd      <= 1'b1;
            matr_rd_addr <= rd_cnt;
            if (rd_cnt == AW'(NWORDS-1)) state <= DRAIN;
            else rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (pop & m.m_last) begin
            state     <= DONE;
            busy      <= 1'b0;
            dump_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  qr_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (matr_rd),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_qr_result_streamer.sv
// Directed bench for qr_result_streamer: RAM model,
// stream sink with ready patterns, per-scenario tasks.
module tb_qr_result_streamer;
  import qr_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic             matr_rd;
  logic [AW-1:0]    matr_rd_addr;
  logic [WIDTH-1:0] matr_di;
  logic             busy;
  logic             dump_done;

  qr_result_streamer_if sif();

  qr_result_streamer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .matr_rd      (matr_rd),
    .matr_rd_addr (matr_rd_addr),
    .matr_di      (matr_di),
    .m            (sif),
    .busy         (busy),
    .dump_done    (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] ram [32];
  assign matr_di = ram[matr_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  int       rd_total = 0;
  int       rd_base  = 0;
  logic [4:0] rd_log [1024];

  always @(posedge clk) begin
    if (reset && matr_rd && rd_total < 1024) begin
      rd_log[rd_total] = matr_rd_addr;
      rd_total = rd_total + 1;
    end
  end

  bit   special = 0;
  logic [12:0] got_data [64];
  int   n_got, bad, last_cnt, stable_bad;
  int   done_cnt, done_c, last_hs_c;
  int   first_valid_c, busy_rise, rd_at_50;
  logic mrd_at_50;

  function automatic logic [12:0] exp_word(input int k);
    if (special && k == 5) return 13'h0FFF;
    if (special && k == 6) return 13'h1000;
    return 13'(k - 16);
  endfunction

  function automatic int rd_order_errs();
    int e = 0;
    if (rd_total - rd_base != 32) e++;
    for (int k = 0; k < 32; k++)
      if (rd_base + k < rd_total)
        if (rd_log[rd_base+k] !== 5'(k)) e++;
    return e;
  endfunction

  task automatic load_ram();
    for (int k = 0; k < 32; k++) ram[k] = exp_word(k);
  endtask

  task automatic new_edge();
    start = 1'b0;
    @(negedge clk);
    rd_base = rd_total;
    start = 1'b1;
  endtask

  // mode 0: ready high, 1: 1,0,0,1, 2: low 50 cycles,
  // 3: ready high plus a second start edge mid-dump.
  task automatic collect(input int mode, input int stop_n,
                         input int limit);
    logic hold, rdy, pb;
    logic [12:0] pd;
    logic [4:0]  pa;
    int tail;
    n_got = 0; bad = 0; last_cnt = 0; stable_bad = 0;
    done_cnt = 0; done_c = -1; last_hs_c = -1;
    first_valid_c = -1; busy_rise = 0; rd_at_50 = -1;
    mrd_at_50 = 1'bx; tail = 0; hold = 0; pb = busy;
    pd = '0; pa = '0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (mode == 3 && c == 8)  start = 1'b0;
      if (mode == 3 && c == 10) start = 1'b1;
      if (busy && !pb) busy_rise++;
      pb = busy;
      if (dump_done) begin done_cnt++; done_c = c; end
      if (c == 49) begin
        rd_at_50  = rd_total - rd_base;
        mrd_at_50 = matr_rd;
      end
      if (sif.m_valid && first_valid_c < 0) first_valid_c = c;
      if (hold && (!sif.m_valid || sif.m_data !== pd ||
                   sif.m_addr !== pa))
        stable_bad++;
      rdy = 1'b1;
      if (mode == 1) rdy = (c % 4 == 0) || (c % 4 == 3);
      if (mode == 2) rdy = (c >= 50);
      if (n_got >= stop_n) rdy = 1'b0;
      sif.m_ready = rdy;
      if (sif.m_valid && rdy) begin
        if (n_got > 31 || sif.m_addr !== 5'(n_got) ||
            sif.m_data !== exp_word(n_got) ||
            sif.m_last !== (n_got == 31))
          bad++;
        if (sif.m_last) last_cnt++;
        if (n_got < 64) got_data[n_got] = sif.m_data;
        n_got++;
        last_hs_c = c;
      end
      hold = sif.m_valid && !rdy;
      pd = sif.m_data;
      pa = sif.m_addr;
      if (n_got >= stop_n) begin
        tail++;
        if (tail > 4) break;
      end
    end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    repeat (3) @(negedge clk);
    outs = {sif.m_valid, sif.m_data, sif.m_addr, sif.m_last,
            matr_rd, matr_rd_addr, busy, dump_done};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0", outs);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_high_release busy got %b want 0", busy);
    end
    n_checks++;
    if (rd_total !== 0) begin
      n_fail++;
      $display("FAIL start_high_release reads got %0d want 0",
               rd_total);
    end
  endtask

  task automatic test_basic();
    new_edge();
    collect(0, 32, 200);
    n_checks++;
    if (n_got !== 32) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 32", n_got);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL basic_words bad %0d want 0", bad);
    end
    n_checks++;
    if (last_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_last got %0d want 1", last_cnt);
    end
    n_checks++;
    if (first_valid_c !== 2) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 2", first_valid_c);
    end
    n_checks++;
    if (last_hs_c !== 33) begin
      n_fail++;
      $display("FAIL basic_throughput got %0d want 33", last_hs_c);
    end
    n_checks++;
    if (done_cnt !== 1 || done_c !== last_hs_c + 1) begin
      n_fail++;
      $display("FAIL basic_done cnt %0d at %0d want 1 at %0d",
               done_cnt, done_c, last_hs_c + 1);
    end
    n_checks++;
    if (rd_order_errs() !== 0) begin
      n_fail++;
      $display("FAIL basic_reads errs %0d want 0", rd_order_errs());
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_end got %b want 0", busy);
    end
  endtask

  task automatic test_ready_toggle();
    new_edge();
    collect(1, 32, 300);
    n_checks++;
    if (n_got !== 32 || bad !== 0) begin
      n_fail++;
      $display("FAIL toggle_words got %0d bad %0d want 32 bad 0",
               n_got, bad);
    end
    n_checks++;
    if (stable_bad !== 0) begin
      n_fail++;
      $display("FAIL toggle_stable got %0d want 0", stable_bad);
    end
    n_checks++;
    if (last_cnt !== 1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL toggle_end last %0d done %0d want 1 1",
               last_cnt, done_cnt);
    end
  endtask

  task automatic test_stall();
    new_edge();
    collect(2, 32, 300);
    n_checks++;
    if (rd_at_50 !== 4) begin
      n_fail++;
      $display("FAIL stall_reads got %0d want 4", rd_at_50);
    end
    n_checks++;
    if (mrd_at_50 !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rd_low got %b want 0", mrd_at_50);
    end
    n_checks++;
    if (n_got !== 32 || bad !== 0 || stable_bad !== 0) begin
      n_fail++;
      $display("FAIL stall_words got %0d bad %0d unstable %0d",
               n_got, bad, stable_bad);
    end
    n_checks++;
    if (rd_order_errs() !== 0) begin
      n_fail++;
      $display("FAIL stall_order errs %0d want 0", rd_order_errs());
    end
  endtask

  task automatic test_second_start();
    new_edge();
    collect(3, 32, 200);
    repeat (8) @(negedge clk);
    n_checks++;
    if (busy_rise !== 1) begin
      n_fail++;
      $display("FAIL restart_busy rises %0d want 1", busy_rise);
    end
    n_checks++;
    if (rd_total - rd_base !== 32) begin
      n_fail++;
      $display("FAIL restart_reads got %0d want 32",
               rd_total - rd_base);
    end
    n_checks++;
    if (n_got !== 32 || bad !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_words got %0d bad %0d done %0d",
               n_got, bad, done_cnt);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] outs;
    int dd;
    new_edge();
    collect(0, 13, 100);
    n_checks++;
    if (n_got !== 13 || bad !== 0) begin
      n_fail++;
      $display("FAIL abort_prefix got %0d bad %0d want 13 0",
               n_got, bad);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    outs = {sif.m_valid, sif.m_data, sif.m_addr, sif.m_last,
            matr_rd, matr_rd_addr, busy, dump_done};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL abort_outs got %h want 0", outs);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dump_done || busy) dd++;
    end
    n_checks++;
    if (dd !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d want 0", dd);
    end
    new_edge();
    collect(0, 32, 200);
    n_checks++;
    if (n_got !== 32 || bad !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_redump got %0d bad %0d done %0d",
               n_got, bad, done_cnt);
    end
    n_checks++;
    if (rd_order_errs() !== 0) begin
      n_fail++;
      $display("FAIL abort_order errs %0d want 0", rd_order_errs());
    end
  endtask

  task automatic test_data_exact();
    special = 1;
    load_ram();
    new_edge();
    collect(0, 32, 200);
    n_checks++;
    if (got_data[5] !== 13'd4095) begin
      n_fail++;
      $display("FAIL exact_pos got %h want 0fff", got_data[5]);
    end
    n_checks++;
    if ($signed(got_data[6]) != -4096 || got_data[6] !== 13'h1000)
    begin
      n_fail++;
      $display("FAIL exact_neg got %h want 1000", got_data[6]);
    end
    n_checks++;
    if (n_got !== 32 || bad !== 0) begin
      n_fail++;
      $display("FAIL exact_words got %0d bad %0d", n_got, bad);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    sif.m_ready = 1'b0;
    special = 0;
    load_ram();
    test_reset();
    test_basic();
    test_ready_toggle();
    test_stall();
    test_second_start();
    test_reset_mid();
    test_data_exact();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
